// File: rtl/mips_mem_pkg.sv
// Shared definitions for the data-memory responder: FSM state encoding and sizing constants.
package mips_mem_pkg;

    localparam int unsigned WORD_BYTES = 4;
    localparam int unsigned CNT_W      = 4;

    typedef enum logic [1:0] {
        StIdle,
        StWait,
        StResp
    } dmr_state_e;

endpackage

// File: rtl/data_mem_responder_if.sv
// Request/response bus between a load/store initiator and the data-memory responder.
interface data_mem_responder_if;

    logic        Req;
    logic        Req_we;
    logic [31:0] Req_addr;
    logic [31:0] Req_wdata;
    logic        Req_ready;
    logic        Resp_valid;
    logic [31:0] Resp_rdata;
    logic        Resp_err;
    logic        Busy;

    modport master (
        output Req, Req_we, Req_addr, Req_wdata,
        input  Req_ready, Resp_valid, Resp_rdata, Resp_err, Busy
    );

    modport slave (
        input  Req, Req_we, Req_addr, Req_wdata,
        output Req_ready, Resp_valid, Resp_rdata, Resp_err, Busy
    );

endinterface

// File: rtl/data_mem_array.sv
// Word storage: synchronous write, registered read, single address port. Contents are not reset.
module data_mem_array #(
    parameter int unsigned ADDR_W = 8
) (
    input  logic              clk_i,
    input  logic              en_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [31:0]       wdata_i,
    output logic [31:0]       rdata_o
);

    logic [31:0] mem_q [1 << ADDR_W];
    logic [31:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (en_i) begin
            if (we_i) begin
                mem_q[addr_i] <= wdata_i;
            end else begin
                rdata_q <= mem_q[addr_i];
            end
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/data_mem_responder.sv
// Data-memory responder: req/ready accept, WAIT_CYCLES wait states, word access, 1-cycle response.
// Optional address checking (misaligned / out of range) is enabled by defining DMR_ERR_CHECK_EN.
module data_mem_responder
    import mips_mem_pkg::*;
#(
    parameter int unsigned ADDR_W      = 8,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic                  CLK,
    input  logic                  RESET,
    data_mem_responder_if.slave   bus
);

    localparam int unsigned      OFF_W   = $clog2(WORD_BYTES);
    localparam int unsigned      LoadVal = (WAIT_CYCLES == 0) ? 0 : WAIT_CYCLES - 1;
    localparam logic [CNT_W-1:0] CntLoad = CNT_W'(LoadVal);

    dmr_state_e        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              err_q, err_d;

    logic              accept;
    logic              req_err;
    logic [ADDR_W-1:0] req_word;
    logic              mem_en, mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata, mem_rdata;

    assign accept   = bus.Req && (state_q == StIdle);
    assign req_word = bus.Req_addr[ADDR_W+OFF_W-1:OFF_W];

`ifdef DMR_ERR_CHECK_EN
    assign req_err = (|bus.Req_addr[OFF_W-1:0]) || (|bus.Req_addr[31:ADDR_W+OFF_W]);
`else
    // Without checking, the byte offset and upper address bits are simply dropped.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{bus.Req_addr[OFF_W-1:0], bus.Req_addr[31:ADDR_W+OFF_W]};
    assign req_err = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        we_d      = we_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        err_d     = err_q;
        mem_en    = 1'b0;
        mem_we    = we_q;
        mem_addr  = addr_q;
        mem_wdata = wdata_q;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    we_d    = bus.Req_we;
                    addr_d  = req_word;
                    wdata_d = bus.Req_wdata;
                    err_d   = req_err;
                    if (req_err) begin
                        state_d = StResp;
                    end else if (WAIT_CYCLES == 0) begin
                        // Zero wait states: access straight from the bus on the accept edge.
                        mem_en    = 1'b1;
                        mem_we    = bus.Req_we;
                        mem_addr  = req_word;
                        mem_wdata = bus.Req_wdata;
                        state_d   = StResp;
                    end else begin
                        cnt_d   = CntLoad;
                        state_d = StWait;
                    end
                end
            end
            StWait: begin
                if (cnt_q == '0) begin
                    mem_en  = 1'b1;
                    state_d = StResp;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            StResp:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            err_q   <= err_d;
        end
    end

    // Reset gates the enable so a request held during reset cannot write the array.
    data_mem_array #(
        .ADDR_W (ADDR_W)
    ) u_array (
        .clk_i   (CLK),
        .en_i    (mem_en && !RESET),
        .we_i    (mem_we),
        .addr_i  (mem_addr),
        .wdata_i (mem_wdata),
        .rdata_o (mem_rdata)
    );

    assign bus.Req_ready  = (state_q == StIdle);
    assign bus.Busy       = (state_q != StIdle);
    assign bus.Resp_valid = (state_q == StResp);
    assign bus.Resp_err   = (state_q == StResp) && err_q;
    assign bus.Resp_rdata = ((state_q == StResp) && !we_q && !err_q) ? mem_rdata : '0;

endmodule

// File: tb/tb_data_mem_responder.sv
// Randomized scoreboard bench for data_mem_responder (WAIT_CYCLES=2 and WAIT_CYCLES=0 instances).
module tb_data_mem_responder;

    localparam int unsigned AW    = 8;
    localparam int unsigned DEPTH = 1 << AW;

    typedef struct {
        int          inst;
        int          due;
        bit          err;
        bit          chk_data;
        logic [31:0] rdata;
    } exp_t;

    logic CLK = 1'b0;
    logic RESET = 1'b1;
    always #5 CLK = ~CLK;

    data_mem_responder_if bus_a ();
    data_mem_responder_if bus_b ();

    data_mem_responder #(.ADDR_W(AW), .WAIT_CYCLES(2)) u_dut2 (
        .CLK (CLK), .RESET (RESET), .bus (bus_a)
    );
    data_mem_responder #(.ADDR_W(AW), .WAIT_CYCLES(0)) u_dut0 (
        .CLK (CLK), .RESET (RESET), .bus (bus_b)
    );

    logic        req_v [2];
    logic        we_v  [2];
    logic [31:0] addr_v[2];
    logic [31:0] wd_v  [2];
    logic        rdy_w [2];
    logic        vld_w [2];
    logic        err_w [2];
    logic        busy_w[2];
    logic [31:0] rd_w  [2];

    assign bus_a.Req = req_v[0];  assign bus_a.Req_we = we_v[0];
    assign bus_a.Req_addr = addr_v[0];  assign bus_a.Req_wdata = wd_v[0];
    assign bus_b.Req = req_v[1];  assign bus_b.Req_we = we_v[1];
    assign bus_b.Req_addr = addr_v[1];  assign bus_b.Req_wdata = wd_v[1];
    assign rdy_w[0] = bus_a.Req_ready;  assign rdy_w[1] = bus_b.Req_ready;
    assign vld_w[0] = bus_a.Resp_valid; assign vld_w[1] = bus_b.Resp_valid;
    assign err_w[0] = bus_a.Resp_err;   assign err_w[1] = bus_b.Resp_err;
    assign busy_w[0] = bus_a.Busy;      assign busy_w[1] = bus_b.Busy;
    assign rd_w[0] = bus_a.Resp_rdata;  assign rd_w[1] = bus_b.Resp_rdata;

    logic [31:0] model_mem  [2][DEPTH];
    bit          model_known[2][DEPTH];
    exp_t        exp_q[$];
    exp_t        mon_e;
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, want, cyc + 1);
        end
    endtask

    function automatic int waitc(input int i);
        return (i == 0) ? 2 : 0;
    endfunction

    function automatic bit addr_err(input logic [31:0] a);
`ifdef DMR_ERR_CHECK_EN
        return (a[1:0] != 2'b00) || ((a >> (AW + 2)) != 0);
`else
        return (a == 32'hffff_ffff) && (a != 32'hffff_ffff);
`endif
    endfunction

    // Monitor: every response pulse is matched against the oldest expectation.
    always @(negedge CLK) begin
        for (int i = 0; i < 2; i++) begin
            if (vld_w[i] === 1'b1) begin
                if (exp_q.size() == 0 || exp_q[0].inst != i) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_resp: inst %0d valid at cycle %0d, expected none",
                             i, cyc + 1);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("resp_cycle", cyc + 1, mon_e.due);
                    check("resp_err", {31'd0, err_w[i]}, {31'd0, mon_e.err});
                    if (mon_e.chk_data) check("resp_rdata", rd_w[i], mon_e.rdata);
                end
            end
        end
    end

    // Build the expectation for a request accepted on the coming edge and update the model.
    task automatic predict(input int i, input bit we, input logic [31:0] a, input logic [31:0] wd);
        exp_t        e;
        bit          err;
        int unsigned w;
        err = addr_err(a);
        w = (a >> 2) % DEPTH;
        e.inst = i;
        e.err = err;
        e.due = cyc + 1 + (err ? 1 : waitc(i) + 1);
        e.rdata = (we || err) ? 32'd0 : model_mem[i][w];
        e.chk_data = we || err || model_known[i][w];
        exp_q.push_back(e);
        if (we && !err) begin
            model_mem[i][w] = wd;
            model_known[i][w] = 1'b1;
        end
    endtask

    task automatic issue(input int i, input bit we, input logic [31:0] a, input logic [31:0] wd,
                         input bit abort);
        bit got;
        @(negedge CLK);
        req_v[i] = 1'b1; we_v[i] = we; addr_v[i] = a; wd_v[i] = wd;
        got = 1'b0;
        for (int t = 0; t < 20; t++) begin
            if (rdy_w[i] === 1'b1) begin
                got = 1'b1;
                break;
            end
            @(negedge CLK);
        end
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: inst %0d got ready=0 expected 1", i);
            req_v[i] = 1'b0;
            return;
        end
        if (!abort) predict(i, we, a, wd);
        @(posedge CLK);
        #1;
        req_v[i] = 1'b0;
    endtask

    task automatic drain();
        for (int t = 0; t < 60 && exp_q.size() != 0; t++) @(negedge CLK);
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL resp_timeout: got %0d pending expected 0", exp_q.size());
            exp_q.delete();
        end
        @(negedge CLK);
    endtask

    task automatic check_reset_outputs(input string tag);
        for (int i = 0; i < 2; i++) begin
            check({tag, "_ready"}, {31'd0, rdy_w[i]}, 32'd1);
            check({tag, "_valid"}, {31'd0, vld_w[i]}, 32'd0);
            check({tag, "_rdata"}, rd_w[i], 32'd0);
            check({tag, "_err"}, {31'd0, err_w[i]}, 32'd0);
            check({tag, "_busy"}, {31'd0, busy_w[i]}, 32'd0);
        end
    endtask

    task automatic random_traffic(input int i, input int n);
        logic [31:0] a;
        int unsigned mode;
        for (int k = 0; k < n; k++) begin
            a = 32'($urandom_range(0, 15)) << 2;
            mode = $urandom_range(0, 5);
            if (mode == 0) a = a | 32'($urandom_range(1, 3));
            else if (mode == 1) a = a | (32'd1 << $urandom_range(AW + 2, 31));
            issue(i, 1'($urandom_range(0, 1)), a, $urandom, 1'b0);
            if ($urandom_range(0, 3) == 0) @(negedge CLK);
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        int acc;
        for (int i = 0; i < 2; i++) begin
            req_v[i] = 1'b0; we_v[i] = 1'b0; addr_v[i] = '0; wd_v[i] = '0;
            for (int w = 0; w < DEPTH; w++) begin
                model_mem[i][w] = '0;
                model_known[i][w] = 1'b0;
            end
        end
        repeat (3) @(negedge CLK);
        check_reset_outputs("in_reset");
        RESET = 1'b0;
        @(negedge CLK);
        check_reset_outputs("after_reset");

        // Basic store/load, error, and wrap/out-of-range cases.
        issue(0, 1'b1, 32'h10, 32'hDEADBEEF, 1'b0);
        issue(0, 1'b0, 32'h10, 32'h0, 1'b0);
        issue(0, 1'b0, 32'h13, 32'h0, 1'b0);
        issue(0, 1'b0, 32'h10, 32'h0, 1'b0);
        issue(0, 1'b1, 32'h0, 32'h11111111, 1'b0);
        issue(0, 1'b1, 32'h400, 32'hCAFEF00D, 1'b0);
        issue(0, 1'b0, 32'h0, 32'h0, 1'b0);
        drain();

        // Request held high: one acceptance every WAIT_CYCLES+2 cycles.
        acc = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge CLK);
            req_v[0] = 1'b1; we_v[0] = 1'b0; addr_v[0] = 32'h10;
            check("hold_ready", {31'd0, rdy_w[0]}, {31'd0, (c % 4) == 0});
            check("hold_busy", {31'd0, busy_w[0]}, {31'd0, (c % 4) != 0});
            if (rdy_w[0] === 1'b1) begin
                predict(0, 1'b0, 32'h10, 32'h0);
                acc++;
            end
        end
        @(posedge CLK);
        #1;
        req_v[0] = 1'b0;
        check("hold_accepts", acc, 3);
        drain();

        // Reset during the wait states drops the store and the response.
        issue(0, 1'b1, 32'h20, 32'h0000AAAA, 1'b0);
        drain();
        issue(0, 1'b1, 32'h20, 32'h00005555, 1'b1);
        RESET = 1'b1;
        @(negedge CLK);
        check_reset_outputs("mid_reset");
        @(negedge CLK);
        RESET = 1'b0;
        repeat (4) @(negedge CLK);
        issue(0, 1'b0, 32'h20, 32'h0, 1'b0);
        drain();

        random_traffic(0, 40);
        drain();

        // Zero-wait-state instance.
        issue(1, 1'b1, 32'h8, 32'h12345678, 1'b0);
        issue(1, 1'b0, 32'h8, 32'h0, 1'b0);
        random_traffic(1, 20);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
